logic_unit_pipe: RTL and testbench

Parametrised, pipelined bitwise logic unit: the sequential successor to the fixed 16-bit NOT/AND/OR/OR-reduce gate set. It takes two WIDTH-bit operands and an operation code through a valid/ready handshake. It returns the registered result plus zero/negative flags two cycles later, at a sustained rate of one operation per cycle under backpressure. It sits between the instruction decode path and the register write-back path, beside the ALU. It serves logic-only instructions and the reduction used for jump conditions.

---
 rtl/logic_unit_pkg.sv | 18 +
 rtl/logic_unit_comb.sv | 44 ++++
 rtl/logic_unit_pipe.sv | 96 +++++++++
 tb/tb_logic_unit_pipe.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined bitwise logic unit.
package logic_unit_pkg;

  localparam int OP_W          = 3;
  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [OP_W-1:0] {
    OP_NOT   = 3'd0,
    OP_AND   = 3'd1,
    OP_OR    = 3'd2,
    OP_XOR   = 3'd3,
    OP_NAND  = 3'd4,
    OP_NOR   = 3'd5,
    OP_ORRED = 3'd6,
    OP_PASS  = 3'd7
  } op_t;

endpackage

// File: rtl/logic_unit_comb.sv
// Purely combinational op decode, per-bit evaluation and result flags.
module logic_unit_comb
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  op_t              i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_neg
);

  logic w_orred;

  assign w_orred = |i_a;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic w_bit;

    // Evaluate the selected operation for this bit position
    always_comb begin
      w_bit = 1'b0;
      case (i_op)
        OP_NOT:   w_bit = ~i_a[gi];
        OP_AND:   w_bit = i_a[gi] & i_b[gi];
        OP_OR:    w_bit = i_a[gi] | i_b[gi];
        OP_XOR:   w_bit = i_a[gi] ^ i_b[gi];
        OP_NAND:  w_bit = ~(i_a[gi] & i_b[gi]);
        OP_NOR:   w_bit = ~(i_a[gi] | i_b[gi]);
        OP_ORRED: w_bit = (gi == 0) ? w_orred : 1'b0;
        OP_PASS:  w_bit = i_a[gi];
        default:  w_bit = 1'b0;
      endcase
    end

    assign o_result[gi] = w_bit;
  end

  assign o_zero = ~|o_result;
  assign o_neg  = o_result[WIDTH-1];

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipelined bitwise logic unit.
// S1 captures operands, S2 holds the evaluated result and flags.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg
);

  logic             r_s1_valid;
  op_t              r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_neg;

  logic             w_s2_load;
  logic             w_in_fire;
  logic [WIDTH-1:0] w_result;
  logic             w_zero;
  logic             w_neg;

  // S2 can take a new entry when empty or when its entry is leaving
  assign w_s2_load = !r_s2_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_load;
  assign w_in_fire = in_valid && in_ready;

  logic_unit_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .i_op     (r_s1_op),
    .i_a      (r_s1_a),
    .i_b      (r_s1_b),
    .o_result (w_result),
    .o_zero   (w_zero),
    .o_neg    (w_neg)
  );

  // Stage 1: capture op and operands on input transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OP_NOT;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
      end
      if (w_in_fire) begin
        r_s1_op <= op_t'(op);
        r_s1_a  <= a;
        r_s1_b  <= b;
      end
    end
  end

  // Stage 2: register the evaluated result and flags when S2 may load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_neg      <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_result;
        r_zero   <= w_zero;
        r_neg    <= w_neg;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign result    = r_result;
  assign neg       = r_neg;
  // Flag only meaningful with a valid result; drained S2 keeps stale data
  assign zero      = r_zero && r_s2_valid;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench: directed literal vectors plus a per-cycle
// scoreboard model for a WIDTH=16 and a WIDTH=8 instance.
module tb_logic_unit_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // WIDTH=16 instance signals
  logic        iv16 = 1'b0, ir16, ov16, ordy16 = 1'b1, z16, n16;
  logic [2:0]  op16 = '0;
  logic [15:0] a16 = '0, b16 = '0, res16;

  // WIDTH=8 instance signals
  logic        iv8 = 1'b0, ir8, ov8, ordy8 = 1'b1, z8, n8;
  logic [2:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0, res8;

  logic_unit_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .op(op16),
    .a(a16), .b(b16), .out_valid(ov16), .out_ready(ordy16), .result(res16),
    .zero(z16), .neg(n16)
  );

  logic_unit_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .op(op8),
    .a(a8), .b(b8), .out_valid(ov8), .out_ready(ordy8), .result(res8),
    .zero(z8), .neg(n8)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference behaviour from the operation table, masked to width w
  function automatic logic [15:0] f_model(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input int w);
    logic [15:0] mask;
    logic [15:0] r;
    mask = (w == 16) ? 16'hFFFF : ((16'h1 << w) - 16'h1);
    case (op)
      3'd0: r = ~a;
      3'd1: r = a & b;
      3'd2: r = a | b;
      3'd3: r = a ^ b;
      3'd4: r = ~(a & b);
      3'd5: r = ~(a | b);
      3'd6: r = ((a & mask) != 16'h0) ? 16'h1 : 16'h0;
      default: r = a;
    endcase
    return r & mask;
  endfunction

  typedef struct {
    logic [15:0] r;
    int          t;
  } ent_t;

  ent_t q0[$];
  ent_t q1[$];
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard step for one instance: capacity, latency, data, order
  task automatic mon(input int k, input logic ir, input logic iv, input logic [2:0] op,
                     input logic [15:0] a, input logic [15:0] b, input logic ov,
                     input logic ordy, input logic [15:0] res, input logic z, input logic n);
    ent_t e;
    int   sz;
    int   w;
    logic exp_ov;
    w  = (k == 0) ? 16 : 8;
    sz = (k == 0) ? q0.size() : q1.size();
    e.r = '0;
    e.t = 0;
    if (sz > 0) e = (k == 0) ? q0[0] : q1[0];
    chk(k == 0 ? "m16_in_ready" : "m8_in_ready", ir, (sz < 2) || ordy);
    exp_ov = (sz > 0) && (cyc >= e.t + 1);
    chk(k == 0 ? "m16_out_valid" : "m8_out_valid", ov, exp_ov);
    if (ov && exp_ov) begin
      chk(k == 0 ? "m16_result" : "m8_result", res, e.r);
      chk(k == 0 ? "m16_zero" : "m8_zero", z, e.r == 16'h0);
      chk(k == 0 ? "m16_neg" : "m8_neg", n, e.r[w-1]);
      if (ordy) begin
        if (k == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
      end
    end
    if (!ov) chk(k == 0 ? "m16_zero_idle" : "m8_zero_idle", z, 1'b0);
    if (iv && ir) begin
      e.r = f_model(op, a, b, w);
      e.t = cyc + 1;
      if (k == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  // Compare process: both instances checked every cycle on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      mon(0, ir16, iv16, op16, a16, b16, ov16, ordy16, res16, z16, n16);
      mon(1, ir8, iv8, op8, {8'h0, a8}, {8'h0, b8}, ov8, ordy8, {8'h0, res8}, z8, n8);
    end
  end

  // Single op through the drained 16-bit pipe with literal expectations
  task automatic run16(input string nm, input logic [2:0] o, input logic [15:0] xa,
                       input logic [15:0] xb, input logic [15:0] er, input logic ez,
                       input logic en);
    @(posedge clk) #1;
    iv16 = 1'b1; op16 = o; a16 = xa; b16 = xb; ordy16 = 1'b1;
    @(negedge clk);
    chk({nm, "_rdy"}, ir16, 1'b1);
    @(posedge clk) #1;
    iv16 = 1'b0;
    @(negedge clk);
    chk({nm, "_lat1"}, ov16, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_valid"}, ov16, 1'b1);
    chk({nm, "_result"}, res16, er);
    chk({nm, "_zero"}, z16, ez);
    chk({nm, "_neg"}, n16, en);
  endtask

  logic [15:0] xa[4];
  logic [15:0] xb[4];
  logic [15:0] xr[4];

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int idx;
    int acc;
    int got;

    xa = '{16'hAAAA, 16'h1234, 16'hFFFF, 16'h0F0F};
    xb = '{16'h5555, 16'h00FF, 16'hFFFF, 16'h00F0};
    xr = '{16'hFFFF, 16'h12CB, 16'h0000, 16'h0FFF};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", ov16, 1'b0);
    chk("rst_result", res16, 16'h0);
    chk("rst_zero", z16, 1'b0);
    chk("rst_neg", n16, 1'b0);
    chk("rst_out_valid8", ov8, 1'b0);
    @(posedge clk) #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", ir16, 1'b1);

    // Directed single operations
    run16("and",    3'd1, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0);
    run16("not",    3'd0, 16'h0000, 16'h1234, 16'hFFFF, 1'b0, 1'b1);
    run16("nor",    3'd5, 16'h8000, 16'h7FFF, 16'h0000, 1'b1, 1'b0);
    run16("orred0", 3'd6, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    run16("orred1", 3'd6, 16'h0100, 16'hFFFF, 16'h0001, 1'b0, 1'b0);

    // Backpressure: out_ready low for five cycles of back-to-back XORs
    idx = 0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk) #1;
      ordy16 = 1'b0; iv16 = 1'b1; op16 = 3'd3; a16 = xa[idx]; b16 = xb[idx];
      @(negedge clk);
      if (ov16) chk("stall_hold", res16, 16'hFFFF);
      if (ir16) begin
        acc++;
        idx++;
      end
    end
    chk("stall_accepted", acc, 2);
    chk("stall_in_ready", ir16, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk) #1;
      ordy16 = 1'b1;
      if (idx < 4) begin
        iv16 = 1'b1; a16 = xa[idx]; b16 = xb[idx];
      end else begin
        iv16 = 1'b0;
      end
      @(negedge clk);
      chk("flow_valid", ov16, 1'b1);
      chk("flow_result", res16, xr[k]);
      if (iv16 && ir16) idx++;
    end
    @(posedge clk) #1;
    iv16 = 1'b0;

    // Asynchronous reset with both stages full
    got = 0;
    for (int c = 0; c < 8 && got < 2; c++) begin
      @(posedge clk) #1;
      ordy16 = 1'b0; iv16 = 1'b1;
      op16 = (got == 0) ? 3'd0 : 3'd3;
      a16 = 16'h0000; b16 = 16'h0000;
      @(negedge clk);
      if (ir16) got++;
    end
    @(posedge clk) #1;
    iv16 = 1'b0;
    chk("rstfill_count", got, 2);
    @(negedge clk);
    chk("rstfill_valid", ov16, 1'b1);
    chk("rstfill_neg", n16, 1'b1);
    @(posedge clk) #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", ov16, 1'b0);
    chk("arst_result", res16, 16'h0);
    chk("arst_zero", z16, 1'b0);
    chk("arst_neg", n16, 1'b0);
    @(negedge clk);
    @(posedge clk) #1;
    rst_n = 1'b1;
    ordy16 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_rst_stale", ov16, 1'b0);
      chk("post_rst_ready", ir16, 1'b1);
    end

    // WIDTH=8 PASS
    @(posedge clk) #1;
    iv8 = 1'b1; op8 = 3'd7; a8 = 8'h80; b8 = 8'h00; ordy8 = 1'b1;
    @(posedge clk) #1;
    iv8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("w8_pass_valid", ov8, 1'b1);
    chk("w8_pass_result", res8, 8'h80);
    chk("w8_pass_neg", n8, 1'b1);
    chk("w8_pass_zero", z8, 1'b0);

    // Random traffic on the WIDTH=8 instance
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk) #1;
      iv8   = 1'($urandom_range(0, 1));
      ordy8 = 1'($urandom_range(0, 1));
      op8   = 3'($urandom_range(0, 7));
      a8    = 8'($urandom);
      b8    = 8'($urandom);
      if ($urandom_range(0, 7) == 0) a8 = 8'h00;
    end
    @(posedge clk) #1;
    iv8 = 1'b0;
    ordy8 = 1'b1;
    repeat (4) @(negedge clk);
    chk("w8_drain_empty", q1.size(), 0);
    chk("w8_drain_valid", ov8, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
